// File: rtl/lsu_rmw.sv
// rtl/lsu_rmw.sv - RV32 load/store unit with word-only memory port and sub-word read-modify-write
package lsu_rmw_pkg;
    localparam logic [2:0] MEM_LB  = 3'd0;
    localparam logic [2:0] MEM_LH  = 3'd1;
    localparam logic [2:0] MEM_LW  = 3'd2;
    localparam logic [2:0] MEM_LBU = 3'd3;
    localparam logic [2:0] MEM_LHU = 3'd4;
    localparam logic [2:0] MEM_SB  = 3'd5;
    localparam logic [2:0] MEM_SH  = 3'd6;
    localparam logic [2:0] MEM_SW  = 3'd7;
endpackage

module lsu_rmw #(
    parameter logic ALIGN_CHECK = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  req_op_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_misalign_o,
    output logic [2:0]  mem_ctrl_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);
    import lsu_rmw_pkg::*;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [2:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_misalign_q;
    logic        req_fault;

    function automatic logic is_load(input logic [2:0] op);
        return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
               (op == MEM_LBU) || (op == MEM_LHU);
    endfunction

    function automatic logic misaligned(input logic [2:0] op, input logic [1:0] lane);
        logic half;
        logic word;
        half = (op == MEM_LH) || (op == MEM_LHU) || (op == MEM_SH);
        word = (op == MEM_LW) || (op == MEM_SW);
        return ALIGN_CHECK && ((half && lane[0]) || (word && (lane != 2'b00)));
    endfunction

    function automatic logic [31:0] extract(input logic [2:0] op, input logic [1:0] lane,
                                            input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = lane[1] ? w[31:16] : w[15:0];
        case (op)
            MEM_LB:  return {{24{b[7]}}, b};
            MEM_LBU: return {24'h0, b};
            MEM_LH:  return {{16{h[15]}}, h};
            MEM_LHU: return {16'h0, h};
            default: return w;
        endcase
    endfunction

    // Sub-word stores splice the new lane into the word captured during READ.
    function automatic logic [31:0] merge(input logic [2:0] op, input logic [1:0] lane,
                                          input logic [31:0] w, input logic [31:0] d);
        logic [31:0] m;
        m = w;
        if (op == MEM_SB) begin
            case (lane)
                2'd0:    m[7:0]   = d[7:0];
                2'd1:    m[15:8]  = d[7:0];
                2'd2:    m[23:16] = d[7:0];
                default: m[31:24] = d[7:0];
            endcase
        end else if (op == MEM_SH) begin
            if (lane[1]) m[31:16] = d[15:0];
            else         m[15:0]  = d[15:0];
        end else begin
            m = d;
        end
        return m;
    endfunction

    assign req_fault = misaligned(req_op_i, req_addr_i[1:0]);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            op_q           <= MEM_LW;
            addr_q         <= 32'h0;
            wdata_q        <= 32'h0;
            word_q         <= 32'h0;
            rsp_rdata_q    <= 32'h0;
            rsp_misalign_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        op_q    <= req_op_i;
                        addr_q  <= req_addr_i;
                        wdata_q <= req_wdata_i;
                        if (req_fault) begin
                            rsp_rdata_q    <= 32'h0;
                            rsp_misalign_q <= 1'b1;
                        end
                    end
                end
                READ: begin
                    word_q <= mem_rdata_i;
                    if (is_load(op_q)) begin
                        rsp_rdata_q    <= extract(op_q, addr_q[1:0], mem_rdata_i);
                        rsp_misalign_q <= 1'b0;
                    end
                end
                WRITE: begin
                    rsp_rdata_q    <= 32'h0;
                    rsp_misalign_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    if (req_fault)              state_d = RESP;
                    else if (req_op_i == MEM_SW) state_d = WRITE;
                    else                        state_d = READ;
                end
            end
            READ:    state_d = is_load(op_q) ? RESP : WRITE;
            WRITE:   state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o    = (state_q == IDLE);
        rsp_valid_o    = (state_q == RESP);
        rsp_rdata_o    = rsp_rdata_q;
        rsp_misalign_o = rsp_misalign_q;
        mem_ctrl_o     = MEM_LW;
        mem_addr_o     = 32'h0;
        mem_wdata_o    = 32'h0;
        if (state_q == READ) begin
            mem_addr_o = {addr_q[31:2], 2'b00};
        end else if (state_q == WRITE) begin
            // Reset gates the write strobe directly so an edge coinciding with reset cannot commit.
            mem_ctrl_o  = rst_i ? MEM_LW : MEM_SW;
            mem_addr_o  = {addr_q[31:2], 2'b00};
            mem_wdata_o = merge(op_q, addr_q[1:0], word_q, wdata_q);
        end
    end

endmodule

// File: tb/tb_lsu_rmw.sv
// tb/tb_lsu_rmw.sv - directed self-checking bench for lsu_rmw
module tb_lsu_rmw;
    import lsu_rmw_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = MEM_LW;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_misalign;
    logic [2:0]  mem_ctrl;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        u1_req_valid = 1'b0;
    logic        u1_req_ready;
    logic [2:0]  u1_req_op = MEM_LW;
    logic [31:0] u1_req_addr = 32'h0;
    logic [31:0] u1_req_wdata = 32'h0;
    logic        u1_rsp_valid;
    logic [31:0] u1_rsp_rdata;
    logic        u1_rsp_misalign;
    logic [2:0]  u1_mem_ctrl;
    logic [31:0] u1_mem_addr;
    logic [31:0] u1_mem_wdata;
    logic [31:0] u1_mem_rdata;

    logic [31:0] mem  [0:255];
    logic [31:0] mem1 [0:255];
    logic        preload = 1'b0;
    int          wr_count = 0;

    int          n_checks = 0;
    int          n_fail = 0;
    int          lat;
    logic [31:0] r_data;
    logic        r_mis;
    logic [2:0]  ctrl_log [1:6];
    logic [31:0] wd_log [1:6];

    always #5 clk = ~clk;

    lsu_rmw #(.ALIGN_CHECK(1'b1)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_op_i(req_op), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_misalign_o(rsp_misalign),
        .mem_ctrl_o(mem_ctrl), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata)
    );

    lsu_rmw #(.ALIGN_CHECK(1'b0)) dut_noalign (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(u1_req_valid), .req_ready_o(u1_req_ready),
        .req_op_i(u1_req_op), .req_addr_i(u1_req_addr), .req_wdata_i(u1_req_wdata),
        .rsp_valid_o(u1_rsp_valid), .rsp_rdata_o(u1_rsp_rdata), .rsp_misalign_o(u1_rsp_misalign),
        .mem_ctrl_o(u1_mem_ctrl), .mem_addr_o(u1_mem_addr), .mem_wdata_o(u1_mem_wdata),
        .mem_rdata_i(u1_mem_rdata)
    );

    assign mem_rdata    = mem[mem_addr[9:2]];
    assign u1_mem_rdata = mem1[u1_mem_addr[9:2]];

    always @(posedge clk) begin
        if (preload) begin
            mem[64]  <= 32'h8899AABB;
            mem[65]  <= 32'h01234567;
            mem1[64] <= 32'h8899AABB;
        end
        if (mem_ctrl == MEM_SW) begin
            mem[mem_addr[9:2]] <= mem_wdata;
            wr_count <= wr_count + 1;
        end
        if (u1_mem_ctrl == MEM_SW) mem1[u1_mem_addr[9:2]] <= u1_mem_wdata;
    end

    task automatic do_preload();
        @(negedge clk); preload = 1'b1;
        @(negedge clk); preload = 1'b0;
    endtask

    // Issues one request and logs the six cycles following the accept edge.
    task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = -1; r_data = 32'hx; r_mis = 1'bx;
        for (int c = 1; c <= 6; c++) begin
            ctrl_log[c] = mem_ctrl;
            wd_log[c]   = mem_wdata;
            if (rsp_valid && lat < 0) begin
                lat = c; r_data = rsp_rdata; r_mis = rsp_misalign;
            end
            if (c < 6) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_checks++; if (req_ready !== 1'b1)     begin n_fail++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
        n_checks++; if (rsp_valid !== 1'b0)     begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        n_checks++; if (rsp_rdata !== 32'h0)    begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", rsp_rdata); end
        n_checks++; if (rsp_misalign !== 1'b0)  begin n_fail++; $display("FAIL reset_misalign: got %b expected 0", rsp_misalign); end
        n_checks++; if (mem_ctrl !== MEM_LW)    begin n_fail++; $display("FAIL reset_ctrl: got %0d expected %0d", mem_ctrl, MEM_LW); end
        n_checks++; if (mem_addr !== 32'h0)     begin n_fail++; $display("FAIL reset_addr: got %h expected 0", mem_addr); end
        n_checks++; if (mem_wdata !== 32'h0)    begin n_fail++; $display("FAIL reset_wdata: got %h expected 0", mem_wdata); end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_byte_loads();
        do_preload();
        do_req(MEM_LB, 32'h101, 32'h0);
        n_checks++; if (lat !== 2)              begin n_fail++; $display("FAIL lb_latency: got %0d expected 2", lat); end
        n_checks++; if (r_data !== 32'hFFFFFFAA) begin n_fail++; $display("FAIL lb_data: got %h expected ffffffaa", r_data); end
        n_checks++; if (r_mis !== 1'b0)         begin n_fail++; $display("FAIL lb_misalign: got %b expected 0", r_mis); end
        do_req(MEM_LBU, 32'h103, 32'h0);
        n_checks++; if (r_data !== 32'h00000088) begin n_fail++; $display("FAIL lbu_data: got %h expected 00000088", r_data); end
    endtask

    task automatic test_byte_store();
        do_preload();
        do_req(MEM_SB, 32'h102, 32'h11);
        n_checks++; if (ctrl_log[1] !== MEM_LW) begin n_fail++; $display("FAIL sb_c1_ctrl: got %0d expected %0d", ctrl_log[1], MEM_LW); end
        n_checks++; if (ctrl_log[2] !== MEM_SW) begin n_fail++; $display("FAIL sb_c2_ctrl: got %0d expected %0d", ctrl_log[2], MEM_SW); end
        n_checks++; if (wd_log[2] !== 32'h8811AABB) begin n_fail++; $display("FAIL sb_wdata: got %h expected 8811aabb", wd_log[2]); end
        n_checks++; if (ctrl_log[3] !== MEM_LW) begin n_fail++; $display("FAIL sb_c3_ctrl: got %0d expected %0d", ctrl_log[3], MEM_LW); end
        n_checks++; if (lat !== 3)              begin n_fail++; $display("FAIL sb_latency: got %0d expected 3", lat); end
        n_checks++; if (r_data !== 32'h0)       begin n_fail++; $display("FAIL sb_rdata: got %h expected 0", r_data); end
        do_req(MEM_LW, 32'h100, 32'h0);
        n_checks++; if (r_data !== 32'h8811AABB) begin n_fail++; $display("FAIL sb_readback: got %h expected 8811aabb", r_data); end
    endtask

    task automatic test_misalign();
        int wr_before;
        do_preload();
        wr_before = wr_count;
        do_req(MEM_SH, 32'h101, 32'h1234);
        n_checks++; if (lat !== 1)              begin n_fail++; $display("FAIL mis_latency: got %0d expected 1", lat); end
        n_checks++; if (r_mis !== 1'b1)         begin n_fail++; $display("FAIL mis_flag: got %b expected 1", r_mis); end
        n_checks++; if (r_data !== 32'h0)       begin n_fail++; $display("FAIL mis_rdata: got %h expected 0", r_data); end
        n_checks++; if (wr_count !== wr_before) begin n_fail++; $display("FAIL mis_no_write: got %0d writes expected %0d", wr_count, wr_before); end
        do_req(MEM_LW, 32'h100, 32'h0);
        n_checks++; if (r_data !== 32'h8899AABB) begin n_fail++; $display("FAIL mis_word_kept: got %h expected 8899aabb", r_data); end
        do_req(MEM_LW, 32'h102, 32'h0);
        n_checks++; if (r_mis !== 1'b1)         begin n_fail++; $display("FAIL mis_lw_flag: got %b expected 1", r_mis); end
    endtask

    task automatic test_align_off();
        int c;
        do_preload();
        @(negedge clk);
        u1_req_valid = 1'b1; u1_req_op = MEM_SH; u1_req_addr = 32'h101; u1_req_wdata = 32'h1234;
        @(posedge clk);
        @(negedge clk);
        u1_req_valid = 1'b0;
        c = 1;
        while (!u1_rsp_valid && c < 8) begin
            @(negedge clk); c++;
        end
        n_checks++; if (c !== 3)                begin n_fail++; $display("FAIL noalign_latency: got %0d expected 3", c); end
        n_checks++; if (u1_rsp_misalign !== 1'b0) begin n_fail++; $display("FAIL noalign_flag: got %b expected 0", u1_rsp_misalign); end
        @(negedge clk);
        n_checks++; if (mem1[64] !== 32'h88991234) begin n_fail++; $display("FAIL noalign_word: got %h expected 88991234", mem1[64]); end
    endtask

    task automatic test_word_halves();
        do_req(MEM_SW, 32'h104, 32'hDEADBEEF);
        n_checks++; if (lat !== 2)              begin n_fail++; $display("FAIL sw_latency: got %0d expected 2", lat); end
        n_checks++; if (wd_log[1] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_wdata: got %h expected deadbeef", wd_log[1]); end
        do_req(MEM_LH, 32'h106, 32'h0);
        n_checks++; if (r_data !== 32'hFFFFDEAD) begin n_fail++; $display("FAIL lh_data: got %h expected ffffdead", r_data); end
        do_req(MEM_LHU, 32'h104, 32'h0);
        n_checks++; if (r_data !== 32'h0000BEEF) begin n_fail++; $display("FAIL lhu_data: got %h expected 0000beef", r_data); end
    endtask

    task automatic test_reset_mid_store();
        int wr_before;
        int seen;
        do_preload();
        wr_before = wr_count;
        @(negedge clk);
        req_valid = 1'b1; req_op = MEM_SB; req_addr = 32'h100; req_wdata = 32'h0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (mem_ctrl !== MEM_SW)    begin n_fail++; $display("FAIL rst_pre_write: got %0d expected %0d", mem_ctrl, MEM_SW); end
        rst = 1'b1;
        #1;
        n_checks++; if (mem_ctrl !== MEM_LW)    begin n_fail++; $display("FAIL rst_ctrl: got %0d expected %0d", mem_ctrl, MEM_LW); end
        n_checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_port: got addr %h wdata %h expected 0 0", mem_addr, mem_wdata); end
        n_checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_hs: got ready %b valid %b expected 1 0", req_ready, rsp_valid); end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        n_checks++; if (seen !== 0)             begin n_fail++; $display("FAIL rst_no_rsp: got %0d responses expected 0", seen); end
        n_checks++; if (wr_count !== wr_before || mem[64] !== 32'h8899AABB) begin n_fail++; $display("FAIL rst_no_commit: got word %h expected 8899aabb", mem[64]); end
    endtask

    task automatic test_back_to_back();
        logic       rdy [1:6];
        logic       vld [1:6];
        logic [31:0] dat [1:6];
        do_preload();
        @(negedge clk);
        req_valid = 1'b1; req_op = MEM_LW; req_addr = 32'h100;
        @(posedge clk);
        @(negedge clk);
        req_addr = 32'h104;
        for (int c = 1; c <= 6; c++) begin
            rdy[c] = req_ready; vld[c] = rsp_valid; dat[c] = rsp_rdata;
            if (c == 4) req_valid = 1'b0;
            if (c < 6) @(negedge clk);
        end
        n_checks++; if (rdy[1] !== 1'b0 || rdy[2] !== 1'b0) begin n_fail++; $display("FAIL b2b_busy: got %b%b expected 00", rdy[1], rdy[2]); end
        n_checks++; if (rdy[3] !== 1'b1 || rdy[4] !== 1'b0) begin n_fail++; $display("FAIL b2b_accept: got %b%b expected 10", rdy[3], rdy[4]); end
        n_checks++; if ({vld[1], vld[2], vld[3], vld[4], vld[5], vld[6]} !== 6'b010010) begin n_fail++; $display("FAIL b2b_rsp_valid: got %b%b%b%b%b%b expected 010010", vld[1], vld[2], vld[3], vld[4], vld[5], vld[6]); end
        n_checks++; if (dat[2] !== 32'h8899AABB) begin n_fail++; $display("FAIL b2b_first: got %h expected 8899aabb", dat[2]); end
        n_checks++; if (dat[5] !== 32'h01234567) begin n_fail++; $display("FAIL b2b_second: got %h expected 01234567", dat[5]); end
        n_checks++; if (dat[6] !== 32'h01234567) begin n_fail++; $display("FAIL b2b_hold: got %h expected 01234567", dat[6]); end
    endtask

    initial begin
        test_reset();
        test_byte_loads();
        test_byte_store();
        test_misalign();
        test_align_off();
        test_word_halves();
        test_reset_mid_store();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
